// File: rtl/sobel_linebuf_ctrl.sv
// rtl/sobel_linebuf_ctrl.sv - row-delay sequencer for the two line memories of the 3x3 Sobel window
// Pixel (x,y) writes mem0 and reads both memories; the next cycle shifts mem0's old row into mem1.
module sobel_linebuf_ctrl #(
  parameter int DATA_WD = 16,
  parameter int IMG_W   = 640,
  parameter int IMG_H   = 480,
  parameter int PTR_WD  = 10,
  parameter int ROW_WD  = 9
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               pix_valid_i,
  input  logic               pix_sof_i,
  input  logic [DATA_WD-1:0] pix_data_i,
  output logic               pix_ready_o,
  output logic [PTR_WD-1:0]  mem_raddr_o,
  output logic               mem_ren_o,
  output logic [PTR_WD-1:0]  mem0_waddr_o,
  output logic               mem0_wen_o,
  output logic [DATA_WD-1:0] mem0_wdata_o,
  input  logic [DATA_WD-1:0] mem0_rdata_i,
  output logic [PTR_WD-1:0]  mem1_waddr_o,
  output logic               mem1_wen_o,
  output logic [DATA_WD-1:0] mem1_wdata_o,
  input  logic [DATA_WD-1:0] mem1_rdata_i,
  output logic               col_valid_o,
  output logic [DATA_WD-1:0] col_top_o,
  output logic [DATA_WD-1:0] col_mid_o,
  output logic [DATA_WD-1:0] col_bot_o,
  output logic [PTR_WD-1:0]  col_x_o,
  output logic [ROW_WD-1:0]  row_y_o,
  output logic               win_valid_o,
  output logic               frame_done_o
);

  typedef enum logic [1:0] {ST_IDLE, ST_FILL, ST_STREAM, ST_DONE} state_e;

  localparam logic [PTR_WD-1:0] X_LAST = PTR_WD'(IMG_W - 1);
  localparam logic [ROW_WD-1:0] Y_LAST = ROW_WD'(IMG_H - 1);
  localparam logic [PTR_WD-1:0] X_TWO  = PTR_WD'(2);
  localparam logic [ROW_WD-1:0] Y_TWO  = ROW_WD'(2);

  state_e               state_q, state_d;
  logic [PTR_WD-1:0]    x_q, x_d;
  logic [ROW_WD-1:0]    y_q, y_d;
  logic                 ready_q, ready_d;
  logic                 col_valid_q, col_valid_d;
  logic                 win_valid_q, win_valid_d;
  logic                 done_q, done_d;
  logic [PTR_WD-1:0]    col_x_q, col_x_d;
  logic [ROW_WD-1:0]    row_y_q, row_y_d;
  logic [DATA_WD-1:0]   bot_q, bot_d;

  logic                 active;
  logic                 last_x;
  logic                 last_pix;
  logic [PTR_WD-1:0]    cur_x;
  logic [ROW_WD-1:0]    cur_y;

  always_comb begin
    // A sof pixel is always (0,0); in IDLE only a sof pixel opens a frame.
    active      = pix_valid_i & ready_q & ((state_q != ST_IDLE) | pix_sof_i);
    cur_x       = pix_sof_i ? '0 : x_q;
    cur_y       = pix_sof_i ? '0 : y_q;
    last_x      = (cur_x == X_LAST);
    last_pix    = last_x & (cur_y == Y_LAST);

    state_d     = state_q;
    x_d         = x_q;
    y_d         = y_q;
    col_valid_d = active;
    win_valid_d = active & (cur_x >= X_TWO) & (cur_y >= Y_TWO);
    col_x_d     = col_x_q;
    row_y_d     = row_y_q;
    bot_d       = bot_q;
    done_d      = (state_q == ST_DONE);

    if (active) begin
      x_d     = last_x ? '0 : cur_x + 1'b1;
      y_d     = last_x ? ((cur_y == Y_LAST) ? '0 : cur_y + 1'b1) : cur_y;
      col_x_d = cur_x;
      row_y_d = cur_y;
      bot_d   = pix_data_i;
    end

    case (state_q)
      ST_DONE: state_d = ST_IDLE;
      default: begin
        if (active) begin
          if (last_pix)           state_d = ST_DONE;
          else if (y_d >= Y_TWO)  state_d = ST_STREAM;
          else                    state_d = ST_FILL;
        end
      end
    endcase

    ready_d = (state_d != ST_DONE);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_IDLE;
      x_q         <= '0;
      y_q         <= '0;
      ready_q     <= 1'b1;
      col_valid_q <= 1'b0;
      win_valid_q <= 1'b0;
      done_q      <= 1'b0;
      col_x_q     <= '0;
      row_y_q     <= '0;
      bot_q       <= '0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      y_q         <= y_d;
      ready_q     <= ready_d;
      col_valid_q <= col_valid_d;
      win_valid_q <= win_valid_d;
      done_q      <= done_d;
      col_x_q     <= col_x_d;
      row_y_q     <= row_y_d;
      bot_q       <= bot_d;
    end
  end

  assign pix_ready_o  = ready_q;
  assign mem_ren_o    = active;
  assign mem_raddr_o  = active ? cur_x : '0;
  assign mem0_wen_o   = active;
  assign mem0_waddr_o = active ? cur_x : '0;
  assign mem0_wdata_o = active ? pix_data_i : '0;

  // Memory read data lands one cycle after the access, alongside the registered column.
  assign mem1_wen_o   = col_valid_q;
  assign mem1_waddr_o = col_x_q;
  assign mem1_wdata_o = col_valid_q ? mem0_rdata_i : '0;
  assign col_valid_o  = col_valid_q;
  assign col_top_o    = col_valid_q ? mem1_rdata_i : '0;
  assign col_mid_o    = col_valid_q ? mem0_rdata_i : '0;
  assign col_bot_o    = bot_q;
  assign col_x_o      = col_x_q;
  assign row_y_o      = row_y_q;
  assign win_valid_o  = win_valid_q;
  assign frame_done_o = done_q;

endmodule

// File: tb/tb_sobel_linebuf_ctrl.sv
// tb/tb_sobel_linebuf_ctrl.sv - randomized bench for sobel_linebuf_ctrl on a 4x4 image
// Line memories are modelled here; expected columns come from a per-row history model.
module tb_sobel_linebuf_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        pix_valid_i = 1'b0;
  logic        pix_sof_i = 1'b0;
  logic [15:0] pix_data_i = '0;
  logic        pix_ready_o;
  logic [1:0]  mem_raddr_o, mem0_waddr_o, mem1_waddr_o, col_x_o, row_y_o;
  logic        mem_ren_o, mem0_wen_o, mem1_wen_o, col_valid_o, win_valid_o, frame_done_o;
  logic [15:0] mem0_wdata_o, mem1_wdata_o, mem0_rdata_i, mem1_rdata_i;
  logic [15:0] col_top_o, col_mid_o, col_bot_o;

  sobel_linebuf_ctrl #(.DATA_WD(16), .IMG_W(4), .IMG_H(4), .PTR_WD(2), .ROW_WD(2)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .pix_valid_i(pix_valid_i), .pix_sof_i(pix_sof_i), .pix_data_i(pix_data_i),
    .pix_ready_o(pix_ready_o),
    .mem_raddr_o(mem_raddr_o), .mem_ren_o(mem_ren_o),
    .mem0_waddr_o(mem0_waddr_o), .mem0_wen_o(mem0_wen_o), .mem0_wdata_o(mem0_wdata_o),
    .mem0_rdata_i(mem0_rdata_i),
    .mem1_waddr_o(mem1_waddr_o), .mem1_wen_o(mem1_wen_o), .mem1_wdata_o(mem1_wdata_o),
    .mem1_rdata_i(mem1_rdata_i),
    .col_valid_o(col_valid_o), .col_top_o(col_top_o), .col_mid_o(col_mid_o),
    .col_bot_o(col_bot_o), .col_x_o(col_x_o), .row_y_o(row_y_o),
    .win_valid_o(win_valid_o), .frame_done_o(frame_done_o)
  );

  always #5 clk = ~clk;

  // Read-before-write line memories with registered read data.
  logic [15:0] m0 [4];
  logic [15:0] m1 [4];
  initial begin
    for (int i = 0; i < 4; i++) begin m0[i] = '0; m1[i] = '0; end
    mem0_rdata_i = '0;
    mem1_rdata_i = '0;
  end
  always @(posedge clk) begin
    if (mem_ren_o) begin
      mem0_rdata_i <= m0[mem_raddr_o];
      mem1_rdata_i <= m1[mem_raddr_o];
    end
    if (mem0_wen_o) m0[mem0_waddr_o] <= mem0_wdata_o;
    if (mem1_wen_o) m1[mem1_waddr_o] <= mem1_wdata_o;
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: row1/row2 hold the last two rows seen at each column.
  typedef struct {
    logic [15:0] top, mid, bot;
    logic [1:0]  x, y;
    logic        win;
  } col_t;

  col_t        pend;
  logic        pend_v = 1'b0;
  logic [15:0] row1 [4];
  logic [15:0] row2 [4];
  logic        in_frame = 1'b0;
  logic [1:0]  mx = '0, my = '0, cx, cy;
  logic        last_d1 = 1'b0, last_d2 = 1'b0;
  logic        acc, eff;
  int          frames_seen = 0;

  initial for (int i = 0; i < 4; i++) begin row1[i] = '0; row2[i] = '0; end

  always @(negedge clk) begin
    if (!rst_n) begin
      in_frame = 1'b0; mx = '0; my = '0; pend_v = 1'b0; last_d1 = 1'b0; last_d2 = 1'b0;
    end else begin
      check("pix_ready", 32'(pix_ready_o), 32'(!last_d1));
      check("frame_done", 32'(frame_done_o), 32'(last_d2));
      check("col_valid", 32'(col_valid_o), 32'(pend_v));
      check("mem1_wen", 32'(mem1_wen_o), 32'(pend_v));
      check("win_valid", 32'(win_valid_o), 32'(pend_v && pend.win));
      if (frame_done_o) frames_seen++;
      if (pend_v) begin
        check("col_x", 32'(col_x_o), 32'(pend.x));
        check("row_y", 32'(row_y_o), 32'(pend.y));
        check("col_bot", 32'(col_bot_o), 32'(pend.bot));
        check("col_mid", 32'(col_mid_o), 32'(pend.mid));
        if (pend.y >= 2'd2) check("col_top", 32'(col_top_o), 32'(pend.top));
        check("mem1_waddr", 32'(mem1_waddr_o), 32'(pend.x));
        check("mem1_wdata", 32'(mem1_wdata_o), 32'(pend.mid));
      end
      acc = pix_valid_i && pix_ready_o;
      eff = acc && (in_frame || pix_sof_i);
      check("mem0_wen", 32'(mem0_wen_o), 32'(eff));
      check("mem_ren", 32'(mem_ren_o), 32'(eff));
      last_d2 = last_d1;
      last_d1 = 1'b0;
      pend_v  = eff;
      if (eff) begin
        cx = pix_sof_i ? 2'd0 : mx;
        cy = pix_sof_i ? 2'd0 : my;
        check("mem0_waddr", 32'(mem0_waddr_o), 32'(cx));
        check("mem_raddr", 32'(mem_raddr_o), 32'(cx));
        check("mem0_wdata", 32'(mem0_wdata_o), 32'(pix_data_i));
        pend.top = row2[cx];
        pend.mid = row1[cx];
        pend.bot = pix_data_i;
        pend.x   = cx;
        pend.y   = cy;
        pend.win = (cx >= 2'd2) && (cy >= 2'd2);
        row2[cx] = row1[cx];
        row1[cx] = pix_data_i;
        if (cx == 2'd3 && cy == 2'd3) begin
          in_frame = 1'b0; last_d1 = 1'b1; mx = '0; my = '0;
        end else begin
          in_frame = 1'b1;
          mx = cx + 2'd1;
          my = (cx == 2'd3) ? cy + 2'd1 : cy;
        end
      end
    end
  end

  task automatic send_pix(input logic [15:0] d, input logic sof, input bit gaps);
    bit acc_l = 0;
    int n = 0;
    pix_valid_i = 1'b1;
    pix_sof_i   = sof;
    pix_data_i  = d;
    while (!acc_l && n < 20) begin
      @(negedge clk);
      acc_l = pix_ready_o;
      @(posedge clk);
      #1;
      n++;
    end
    if (!acc_l) check("accept_timeout", 32'(0), 32'(1));
    pix_valid_i = 1'b0;
    pix_sof_i   = 1'b0;
    pix_data_i  = 16'($urandom);
    if (gaps && $urandom_range(0, 1) == 1) begin
      repeat ($urandom_range(1, 2)) @(posedge clk);
      #1;
    end
  endtask

  task automatic send_frame(input logic [15:0] base, input bit rnd, input bit gaps, input int npix);
    for (int i = 0; i < npix; i++) begin
      send_pix(rnd ? 16'($urandom) : base + 16'(16 * (i / 4) + (i % 4)), i == 0, gaps);
    end
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("reset_ready", 32'(pix_ready_o), 32'(1));
    check("reset_outs", 32'({col_valid_o, win_valid_o, frame_done_o, mem0_wen_o, mem1_wen_o,
                             mem_ren_o, col_x_o, row_y_o}), 32'(0));
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) send_pix(16'($urandom), 1'b0, 1'b0);
    send_frame(16'h0000, 1'b0, 1'b0, 16);
    send_frame(16'h0080, 1'b0, 1'b0, 16);
    send_frame(16'h0000, 1'b1, 1'b1, 16);
    send_frame(16'h0040, 1'b0, 1'b1, 9);
    send_frame(16'h00c0, 1'b0, 1'b0, 16);
    send_frame(16'h0000, 1'b1, 1'b0, 6);
    repeat (2) @(posedge clk);
    #2;
    pix_valid_i = 1'b1;
    pix_sof_i   = 1'b0;
    rst_n       = 1'b0;
    #1;
    check("async_rst_ready", 32'(pix_ready_o), 32'(1));
    check("async_rst_ctl", 32'({col_valid_o, win_valid_o, frame_done_o, mem0_wen_o, mem1_wen_o,
                                mem_ren_o, col_x_o, row_y_o}), 32'(0));
    check("async_rst_data", 32'({col_top_o, col_mid_o}), 32'(0));
    check("async_rst_mem", 32'({mem1_wdata_o, mem0_wdata_o}), 32'(0));
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    pix_valid_i = 1'b0;
    @(posedge clk);
    #1;
    send_frame(16'h0000, 1'b1, 1'b1, 16);
    repeat (4) @(posedge clk);
    #1;
    check("frames_done", 32'(frames_seen), 32'(5));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
